group_project: RTL and testbench
================================

# group_project

Board-level top for the branch-prediction demo on a 50 MHz board. It runs a self-contained fetch sequencer over a hardwired loop and shortcuts the loop-closing branch through a small branch target buffer (BTB) when SW[0] is set. It counts loop iterations and mispredicts, and periodically reports the mispredict count over a UART transmitter on GPIO[3].

## Interface
- LOOP_START, 16'h0000: branch target address of the hardwired loop.
- LOOP_END, 16'h000F: address of the always-taken branch; must be greater than LOOP_START.
- CLKS_PER_BIT, 434: UART bit period in clocks (115200 baud at 50 MHz).
- REPORT_MASK, 6: report once every 2^REPORT_MASK loop iterations.
- CLOCK_50  in  1: system clock; single clock domain.
- KEY  in  4: KEY[0] is the reset, asynchronous and active-low. KEY[3:1] are unused.
- SW  in  10: SW[0] is the BTB enable. SW[9:1] are unused.
- GPIO  inout  36: GPIO[3] is UART TX, push-pull. All other bits are high-Z.

## Operation
- Reset synchronizer: KEY[0] low asserts the internal reset immediately. Release passes through 2 flops on CLOCK_50.
- SW[0] synchronizer: 2-flop synchronizer producing btb_on.
- Fetch stage: 16-bit PC, one fetch per cycle.
- Resolve stage registers: r_pc, r_pred (the BTB hit was used), r_valid.
- Next-PC priority, highest first:
  - Resolve redirect.
  - BTB hit at PC → target.
  - PC+1.
- BTB:
  - 8 entries, direct-mapped.
  - Index PC[2:0]; tag PC[15:3]; 16-bit target; valid bit.
  - Lookup is combinational on PC; a hit requires valid, tag match and btb_on.
- Resolve stage, when r_valid=1:
  - r_pc==LOOP_END and !r_pred (missed taken branch): redirect PC to LOOP_START; clear r_valid for the next cycle (squash the wrong-path fetch); increment mispred_cnt; write entry {tag, LOOP_START, valid} if btb_on.
  - r_pc!=LOOP_END and r_pred (false prediction): redirect PC to r_pc+1; squash; increment mispred_cnt; clear that entry's valid bit.
  - r_pc==LOOP_END: increment iter_cnt. This applies whether or not the branch was predicted.
- Counters: iter_cnt and mispred_cnt are 16 bits and wrap modulo 2^16.
- btb_on=0: no hits and no writes. Entry contents are retained, so re-enabling resumes with the prior contents.
- Report trigger: an iter_cnt increment that makes iter_cnt[REPORT_MASK-1:0]==0.
  - If the UART is idle, load mispred_cnt[7:0].
  - If the UART is busy, drop the report (no queue).
- UART TX: 8N1, LSB first, idle high, CLKS_PER_BIT clocks per bit, 10-bit frame.

## Timing
- Reset values:
  - PC=LOOP_START.
  - r_valid=0.
  - All BTB valid bits 0.
  - iter_cnt=0, mispred_cnt=0.
  - UART idle; GPIO[3]=1.
- The first fetch occurs on the first clock edge after the synchronized reset releases.
- Loop period:
  - LOOP_END-LOOP_START+1 cycles (16 by default) with a BTB hit.
  - One cycle more (17) on a miss, because of the one-cycle bubble.
- btb_on applies 2 cycles after SW[0] changes.
- A resolve redirect and a BTB hit in the same cycle: the redirect wins.
- Reset asserted mid-run: all state returns to reset values at once, including an aborted UART frame; GPIO[3] goes high immediately.
- UART frame duration: 10×CLKS_PER_BIT cycles.
- A frame load and a report trigger in the same cycle: the trigger is dropped.

## Configuration
- GROUP_PROJECT_BTB_EN defined: BTB instantiated; behaviour as above.
- GROUP_PROJECT_BTB_EN undefined:
  - No BTB storage; hits are forced to 0 and SW[0] is ignored.
  - Every loop iteration mispredicts: mispred_cnt tracks iter_cnt and the period is always LOOP_END-LOOP_START+2 cycles.

## Test plan
- SW[0]=1, reset released → PC sequence 0..15, 16 (squashed), 0. After the first iteration the sequence is 0..15, 0 with no bubble. After 100 iterations, mispred_cnt=1 and iter_cnt=100.
- SW[0]=0 → each iteration is 17 cycles; after 100 iterations, mispred_cnt=100.
- SW[0] toggled 1→0 → hits stop 2 cycles later; mispred_cnt increments every iteration.
- SW[0] toggled back to 1 → the retained entry hits with no new mispredict.
- CLKS_PER_BIT=4, REPORT_MASK=2, SW[0]=0:
  - At iter_cnt=4, GPIO[3] emits start bit 0, then data 0x04 LSB first, then stop bit 1; each bit lasts 4 clocks.
  - The next report at iter_cnt=8 sends 0x08.
- KEY[0] pulled low mid-frame → GPIO[3]=1 immediately. After release: PC=0, both counters 0, BTB empty; the first iteration mispredicts again.
- Build without GROUP_PROJECT_BTB_EN, SW[0]=1 → identical to the SW[0]=0 case; after 100 iterations, mispred_cnt=100.

Source files
------------

// File: rtl/group_project.sv
// group_project: branch-prediction demo top. Fetch loop with BTB shortcut, iteration/mispredict counters, UART reporter.
// Ports: CLOCK_50 clock; KEY[0] async active-low reset; SW[0] BTB enable; GPIO[3] UART TX. Optional BTB: `GROUP_PROJECT_BTB_EN.
module group_project #(
  parameter logic [15:0] LOOP_START   = 16'h0000,
  parameter logic [15:0] LOOP_END     = 16'h000F,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          REPORT_MASK  = 6
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  inout  wire [35:0] GPIO
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic clk;
  assign clk = CLOCK_50;

  // reset: asserts at once, releases after two clocks
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge KEY[0]) begin
    if (!KEY[0]) rst_q <= '0;
    else         rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] r_pc;
  logic        r_pred;
  logic        r_valid;
  logic        btb_on;
  logic        hit;
  logic [15:0] hit_tgt;
  logic        is_end;
  logic        miss;
  logic        false_pred;
  logic        redir;
  logic [15:0] redir_pc;
  logic        wr_en;
  logic        clr_en;

  assign is_end     = r_valid && (r_pc == LOOP_END);
  assign miss       = is_end && !r_pred;
  assign false_pred = r_valid && (r_pc != LOOP_END) && r_pred;
  assign redir      = miss || false_pred;
  assign redir_pc   = miss ? LOOP_START : r_pc + 16'd1;
  assign wr_en      = miss && btb_on;
  assign clr_en     = false_pred && btb_on;

`ifdef GROUP_PROJECT_BTB_EN
  logic [1:0]  sw_q;
  logic [7:0]  btb_v;
  logic [12:0] btb_tag [8];
  logic [15:0] btb_tgt [8];
  logic [2:0]  f_idx;
  logic [2:0]  r_idx;
  logic        unused_io;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_q <= '0;
    else        sw_q <= {sw_q[0], SW[0]};
  end

  assign btb_on  = sw_q[1];
  assign f_idx   = pc[2:0];
  assign r_idx   = r_pc[2:0];
  assign hit     = btb_on && btb_v[f_idx]
                   && (btb_tag[f_idx] == pc[15:3]);
  assign hit_tgt = btb_tgt[f_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      btb_v        <= '0;
    else if (wr_en)  btb_v[r_idx] <= 1'b1;
    else if (clr_en) btb_v[r_idx] <= 1'b0;
  end

  // payload needs no reset; valid bits gate it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      btb_tag[r_idx] <= r_pc[15:3];
      btb_tgt[r_idx] <= LOOP_START;
    end
  end

  assign unused_io = ^{KEY[3:1], SW[9:1]};
`else
  logic unused_io;

  assign btb_on    = 1'b0;
  assign hit       = 1'b0;
  assign hit_tgt   = LOOP_START;
  assign unused_io = ^{KEY[3:1], SW, wr_en, clr_en};
`endif

  // redirect beats a same-cycle BTB hit
  always_comb begin
    pc_nxt = pc + 16'd1;
    if (redir)    pc_nxt = redir_pc;
    else if (hit) pc_nxt = hit_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= LOOP_START;
      r_pc    <= LOOP_START;
      r_pred  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      r_pc    <= pc;
      r_pred  <= hit;
      r_valid <= !redir;
    end
  end

  logic [15:0] iter_cnt;
  logic [15:0] mispred_cnt;
  logic [15:0] iter_nxt;
  logic [15:0] mis_nxt;
  logic        trig;
  logic        busy;
  logic        load;
  logic [7:0]  rpt_byte;

  assign iter_nxt = iter_cnt + 16'd1;
  assign mis_nxt  = mispred_cnt + 16'd1;
  assign trig     = is_end && (iter_nxt[REPORT_MASK-1:0] == '0);
  assign load     = trig && !busy;
  // report reflects the mispredict counted in this same cycle
  assign rpt_byte = redir ? mis_nxt[7:0] : mispred_cnt[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (is_end) iter_cnt    <= iter_nxt;
      if (redir)  mispred_cnt <= mis_nxt;
    end
  end

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } ust_t;

  ust_t        ust;
  logic [CW-1:0] ucnt;
  logic [2:0]  bitn;
  logic [7:0]  dsh;
  logic        tx;
  logic        bit_end;

  assign busy    = (ust != U_IDLE);
  assign bit_end = (ucnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ust  <= U_IDLE;
      ucnt <= '0;
      bitn <= '0;
      dsh  <= '0;
      tx   <= 1'b1;
    end else begin
      unique case (ust)
        U_IDLE: begin
          tx   <= 1'b1;
          ucnt <= '0;
          if (load) begin
            dsh <= rpt_byte;
            tx  <= 1'b0;
            ust <= U_START;
          end
        end
        U_START: begin
          if (bit_end) begin
            ucnt <= '0;
            tx   <= dsh[0];
            dsh  <= {1'b0, dsh[7:1]};
            bitn <= '0;
            ust  <= U_DATA;
          end else begin
            ucnt <= ucnt + 1'b1;
          end
        end
        U_DATA: begin
          if (bit_end) begin
            ucnt <= '0;
            if (bitn == 3'd7) begin
              tx  <= 1'b1;
              ust <= U_STOP;
            end else begin
              tx   <= dsh[0];
              dsh  <= {1'b0, dsh[7:1]};
              bitn <= bitn + 3'd1;
            end
          end else begin
            ucnt <= ucnt + 1'b1;
          end
        end
        U_STOP: begin
          if (bit_end) begin
            ucnt <= '0;
            ust  <= U_IDLE;
          end else begin
            ucnt <= ucnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign GPIO[35:4] = 'z;
  assign GPIO[3]    = tx;
  assign GPIO[2:0]  = 'z;

endmodule

// File: tb/tb_group_project.sv
// tb_group_project: scoreboard bench for group_project.
// Decodes UART frames on GPIO[3] against queued expectations; probes loop state.
module tb_group_project;

  localparam int CPB = 4;
`ifdef GROUP_PROJECT_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] sw;
  wire [35:0] gpio;

  always #10 clk = ~clk;

  group_project #(
    .CLKS_PER_BIT(CPB),
    .REPORT_MASK (2)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .GPIO    (gpio)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  byte unsigned exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic get_frame(output byte unsigned d, output int t0,
                           output bit ok);
    ok = 1'b0;
    d  = 8'd0;
    t0 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (gpio[3] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t0 = cyc;
    repeat (CPB / 2) @(negedge clk);
    if (gpio[3] !== 1'b0) ok = 1'b0;
    for (int b = 0; b < 8; b++) begin
      repeat (CPB) @(negedge clk);
      d[b] = gpio[3];
    end
    repeat (CPB) @(negedge clk);
    if (gpio[3] !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_frames(input int n, input int gap);
    byte unsigned d;
    byte unsigned e;
    int t0;
    int tp;
    bit ok;
    tp = 0;
    for (int k = 0; k < n; k++) begin
      get_frame(d, t0, ok);
      chk("frame_ok", 32'(ok), 32'd1);
      e = 8'hEE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("frame_data", 32'(d), 32'(e));
      if (k > 0) chk("frame_gap", 32'(t0 - tp), 32'(gap));
      tp = t0;
    end
  endtask

  task automatic wait_iter(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.iter_cnt == 16'(target)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("iter_wait", 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input logic sw0);
    key[0] = 1'b0;
    sw[0]  = sw0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    key[0] = 1'b1;
  endtask

  int pc_seq[$];
  int nbad;
  int m;
  int e;
  bit ok;

  initial begin
    key = 4'hE;
    sw  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(gpio[3]), 32'd1);
    chk("rst_pc", 32'(dut.pc), 32'd0);
    chk("rst_iter", 32'(dut.iter_cnt), 32'd0);
    chk("rst_mis", 32'(dut.mispred_cnt), 32'd0);
    chk("rst_rvalid", 32'(dut.r_valid), 32'd0);

    // SW[0]=0: every iteration mispredicts, 17-cycle period
    key[0] = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(4 * k));
    rx_frames(4, 68);
    wait_iter(100, 2000);
    chk("a_mis100", 32'(dut.mispred_cnt), 32'd100);

    // SW[0]=1: PC trace of the first two iterations
    do_reset(1'b1);
    for (int it = 0; pc_seq.size() < 45; it++) begin
      for (int p = 0; p < 16; p++) pc_seq.push_back(p);
      if (it == 0 || !BTB) pc_seq.push_back(16);
    end
    nbad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e = (k == 1) ? 0 : pc_seq[k-2];
      if (int'(dut.pc) != e) nbad++;
    end
    chk("pc_seq", 32'(nbad), 32'd0);
    for (int k = 1; k <= 3; k++) exp_q.push_back(BTB ? 8'd1 : 8'(4 * k));
    rx_frames(3, BTB ? 64 : 68);
    wait_iter(100, 2000);
    chk("b_mis100", 32'(dut.mispred_cnt), BTB ? 32'd1 : 32'd100);

    // toggle BTB off then back on
    wait_iter(101, 100);
    sw[0] = 1'b0;
    m = int'(dut.mispred_cnt);
    wait_iter(111, 300);
    chk("off_mis", 32'(dut.mispred_cnt), 32'(m + 10));
    wait_iter(112, 100);
    sw[0] = 1'b1;
    m = int'(dut.mispred_cnt);
    wait_iter(122, 300);
    chk("on_mis", 32'(dut.mispred_cnt), BTB ? 32'(m) : 32'(m + 10));

    // reset pulled mid-frame
    do_reset(1'b1);
    exp_q.push_back(BTB ? 8'd1 : 8'd4);
    rx_frames(1, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gpio[3] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("c_start", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    key[0] = 1'b0;
    #1;
    chk("c_tx_high", 32'(gpio[3]), 32'd1);
    chk("c_pc", 32'(dut.pc), 32'd0);
    chk("c_iter", 32'(dut.iter_cnt), 32'd0);
    chk("c_mis", 32'(dut.mispred_cnt), 32'd0);
`ifdef GROUP_PROJECT_BTB_EN
    chk("c_btb_v", 32'(dut.btb_v), 32'd0);
`endif
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    exp_q.delete();
    wait_iter(1, 100);
    chk("c_first_mis", 32'(dut.mispred_cnt), 32'd1);
    exp_q.push_back(BTB ? 8'd1 : 8'd4);
    rx_frames(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
